// File: rtl/sid_reg_if_if.sv
// Host bus of the tt_um_sid register port: strobe/voice/address byte plus data byte.
interface sid_reg_if_if;
  logic [7:0] ui_in;
  logic [7:0] uio_in;

  modport master (output ui_in, output uio_in);
  modport slave  (input ui_in, input uio_in);
endinterface

// File: rtl/sid_reg_if.sv
// Register-write responder for the tt_um_sid host bus: synchronises the strobe, commits
// one byte per strobe rising edge into voice or filter registers, emits gate-edge events.
module sid_reg_if #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NUM_VOICES  = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  sid_reg_if_if.slave                bus,
  output logic [16*NUM_VOICES-1:0]   freq_o,
  output logic [12*NUM_VOICES-1:0]   pw_o,
  output logic [8*NUM_VOICES-1:0]    ad_o,
  output logic [8*NUM_VOICES-1:0]    sr_o,
  output logic [8*NUM_VOICES-1:0]    ctrl_o,
  output logic [10:0]                fc_o,
  output logic [7:0]                 res_filt_o,
  output logic [7:0]                 mode_vol_o,
  output logic [NUM_VOICES-1:0]      gate_rise_o,
  output logic [NUM_VOICES-1:0]      gate_fall_o,
  output logic                       wr_pulse_o,
  output logic                       bad_addr_o
);

  localparam int unsigned SyncW = 14;

  logic [SYNC_STAGES-1:0][SyncW-1:0] sync_q;
  logic [SYNC_STAGES-1:0]            fill_q;
  logic                              s_prev_q;
  logic                              armed_q;

  logic       s_stb;
  logic [7:0] s_data;
  logic [1:0] s_voice;
  logic [2:0] s_addr;
  logic       commit;

  logic [NUM_VOICES-1:0][15:0] freq_q, freq_d;
  logic [NUM_VOICES-1:0][11:0] pw_q, pw_d;
  logic [NUM_VOICES-1:0][7:0]  ad_q, ad_d;
  logic [NUM_VOICES-1:0][7:0]  sr_q, sr_d;
  logic [NUM_VOICES-1:0][7:0]  ctrl_q, ctrl_d;
  logic [2:0]                  fc_lo_q, fc_lo_d;
  logic [7:0]                  fc_hi_q, fc_hi_d;
  logic [7:0]                  res_filt_q, res_filt_d;
  logic [7:0]                  mode_vol_q, mode_vol_d;
  logic [NUM_VOICES-1:0]       rise_q, rise_d;
  logic [NUM_VOICES-1:0]       fall_q, fall_d;
  logic                        wr_q, wr_d;
  logic                        bad_q, bad_d;

  assign {s_stb, s_data, s_voice, s_addr} = sync_q[SYNC_STAGES-1];

  // fill_q marks stages holding genuinely sampled bus values; the strobe must be seen low in a
  // genuine sample before a rise can commit, so a strobe held across reset release is ignored.
  assign commit = s_stb & ~s_prev_q & armed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      fill_q   <= '0;
      s_prev_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], {bus.ui_in[7], bus.uio_in, bus.ui_in[4:0]}};
      fill_q   <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      s_prev_q <= s_stb;
      if (fill_q[SYNC_STAGES-1] && !s_stb) begin
        armed_q <= 1'b1;
      end
    end
  end

  always_comb begin
    freq_d     = freq_q;
    pw_d       = pw_q;
    ad_d       = ad_q;
    sr_d       = sr_q;
    ctrl_d     = ctrl_q;
    fc_lo_d    = fc_lo_q;
    fc_hi_d    = fc_hi_q;
    res_filt_d = res_filt_q;
    mode_vol_d = mode_vol_q;
    rise_d     = '0;
    fall_d     = '0;
    wr_d       = commit;
    bad_d      = 1'b0;
    if (commit) begin
      if (s_voice == 2'd3) begin
        case (s_addr)
          3'd0:    fc_lo_d    = s_data[2:0];
          3'd1:    fc_hi_d    = s_data;
          3'd2:    res_filt_d = s_data;
          3'd3:    mode_vol_d = s_data;
          default: bad_d      = 1'b1;
        endcase
      end else if ({30'd0, s_voice} < NUM_VOICES) begin
        case (s_addr)
          3'd0: freq_d[s_voice][7:0]  = s_data;
          3'd1: freq_d[s_voice][15:8] = s_data;
          3'd2: pw_d[s_voice][7:0]    = s_data;
          3'd3: pw_d[s_voice][11:8]   = s_data[3:0];
          3'd4: ad_d[s_voice]         = s_data;
          3'd5: sr_d[s_voice]         = s_data;
          3'd6: begin
            ctrl_d[s_voice] = s_data;
            rise_d[s_voice] = s_data[0] & ~ctrl_q[s_voice][0];
            fall_d[s_voice] = ~s_data[0] & ctrl_q[s_voice][0];
          end
          default: bad_d = 1'b1;
        endcase
      end else begin
        bad_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_q     <= '0;
      pw_q       <= '0;
      ad_q       <= '0;
      sr_q       <= '0;
      ctrl_q     <= '0;
      fc_lo_q    <= '0;
      fc_hi_q    <= '0;
      res_filt_q <= '0;
      mode_vol_q <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      wr_q       <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      freq_q     <= freq_d;
      pw_q       <= pw_d;
      ad_q       <= ad_d;
      sr_q       <= sr_d;
      ctrl_q     <= ctrl_d;
      fc_lo_q    <= fc_lo_d;
      fc_hi_q    <= fc_hi_d;
      res_filt_q <= res_filt_d;
      mode_vol_q <= mode_vol_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      wr_q       <= wr_d;
      bad_q      <= bad_d;
    end
  end

  assign freq_o      = freq_q;
  assign pw_o        = pw_q;
  assign ad_o        = ad_q;
  assign sr_o        = sr_q;
  assign ctrl_o      = ctrl_q;
  assign fc_o        = {fc_hi_q, fc_lo_q};
  assign res_filt_o  = res_filt_q;
  assign mode_vol_o  = mode_vol_q;
  assign gate_rise_o = rise_q;
  assign gate_fall_o = fall_q;
  assign wr_pulse_o  = wr_q;
  assign bad_addr_o  = bad_q;

endmodule

// File: tb/tb_sid_reg_if.sv
// Bench for sid_reg_if: register-map model checked every cycle plus directed literal checks.
module tb_sid_reg_if;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sid_reg_if_if bus_if ();

  logic [47:0] freq;
  logic [35:0] pw;
  logic [23:0] ad, sr, ctrl;
  logic [10:0] fc;
  logic [7:0]  res_filt, mode_vol;
  logic [2:0]  gate_rise, gate_fall;
  logic        wr_pulse, bad_addr;

  sid_reg_if #(.SYNC_STAGES(2), .NUM_VOICES(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_if),
    .freq_o      (freq),
    .pw_o        (pw),
    .ad_o        (ad),
    .sr_o        (sr),
    .ctrl_o      (ctrl),
    .fc_o        (fc),
    .res_filt_o  (res_filt),
    .mode_vol_o  (mode_vol),
    .gate_rise_o (gate_rise),
    .gate_fall_o (gate_fall),
    .wr_pulse_o  (wr_pulse),
    .bad_addr_o  (bad_addr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: bus samples taken at each clock edge; a write happens two edges after the first
  // edge that sees the strobe high, provided the edge before that saw it low after reset.
  typedef struct {
    logic       vld;
    logic       stb;
    logic [1:0] voice;
    logic [2:0] addr;
    logic [7:0] data;
  } samp_t;

  samp_t       hs[4];
  logic [15:0] m_freq[3];
  logic [11:0] m_pw[3];
  logic [7:0]  m_ad[3], m_sr[3], m_ctrl[3];
  logic [2:0]  m_fc_lo;
  logic [7:0]  m_fc_hi, m_res, m_mode;
  logic [2:0]  e_rise, e_fall;
  logic        e_wr, e_bad;
  int          cnt_wr = 0, cnt_bad = 0;
  int          cnt_rise[3], cnt_fall[3];

  task automatic model_clear();
    for (int i = 0; i < 4; i++) hs[i] = '{vld: 1'b0, stb: 1'b0, voice: 2'd0, addr: 3'd0, data: 8'd0};
    for (int v = 0; v < 3; v++) begin
      m_freq[v] = '0; m_pw[v] = '0; m_ad[v] = '0; m_sr[v] = '0; m_ctrl[v] = '0;
    end
    m_fc_lo = '0; m_fc_hi = '0; m_res = '0; m_mode = '0;
    e_rise = '0; e_fall = '0; e_wr = 1'b0; e_bad = 1'b0;
  endtask

  task automatic model_write(input samp_t s);
    e_wr = 1'b1;
    if (s.voice == 2'd3) begin
      case (s.addr)
        3'd0: m_fc_lo = s.data[2:0];
        3'd1: m_fc_hi = s.data;
        3'd2: m_res   = s.data;
        3'd3: m_mode  = s.data;
        default: e_bad = 1'b1;
      endcase
    end else begin
      case (s.addr)
        3'd0: m_freq[s.voice][7:0]  = s.data;
        3'd1: m_freq[s.voice][15:8] = s.data;
        3'd2: m_pw[s.voice][7:0]    = s.data;
        3'd3: m_pw[s.voice][11:8]   = s.data[3:0];
        3'd4: m_ad[s.voice]         = s.data;
        3'd5: m_sr[s.voice]         = s.data;
        3'd6: begin
          e_rise[s.voice] = s.data[0] && !m_ctrl[s.voice][0];
          e_fall[s.voice] = !s.data[0] && m_ctrl[s.voice][0];
          m_ctrl[s.voice] = s.data;
        end
        default: e_bad = 1'b1;
      endcase
    end
  endtask

  initial begin
    model_clear();
    for (int v = 0; v < 3; v++) begin cnt_rise[v] = 0; cnt_fall[v] = 0; end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_clear();
      end else begin
        e_rise = '0; e_fall = '0; e_wr = 1'b0; e_bad = 1'b0;
        for (int i = 3; i > 0; i--) hs[i] = hs[i-1];
        hs[0] = '{vld: 1'b1, stb: bus_if.ui_in[7], voice: bus_if.ui_in[4:3],
                  addr: bus_if.ui_in[2:0], data: bus_if.uio_in};
        if (hs[2].stb && hs[3].vld && !hs[3].stb) model_write(hs[2]);
      end
      #1;
      chk("freq", 64'(freq), 64'({m_freq[2], m_freq[1], m_freq[0]}));
      chk("pw", 64'(pw), 64'({m_pw[2], m_pw[1], m_pw[0]}));
      chk("ad", 64'(ad), 64'({m_ad[2], m_ad[1], m_ad[0]}));
      chk("sr", 64'(sr), 64'({m_sr[2], m_sr[1], m_sr[0]}));
      chk("ctrl", 64'(ctrl), 64'({m_ctrl[2], m_ctrl[1], m_ctrl[0]}));
      chk("fc", 64'(fc), 64'({m_fc_hi, m_fc_lo}));
      chk("res_filt", 64'(res_filt), 64'(m_res));
      chk("mode_vol", 64'(mode_vol), 64'(m_mode));
      chk("gate_rise", 64'(gate_rise), 64'(e_rise));
      chk("gate_fall", 64'(gate_fall), 64'(e_fall));
      chk("wr_pulse", 64'(wr_pulse), 64'(e_wr));
      chk("bad_addr", 64'(bad_addr), 64'(e_bad));
      cnt_wr  += int'(wr_pulse);
      cnt_bad += int'(bad_addr);
      for (int v = 0; v < 3; v++) begin
        cnt_rise[v] += int'(gate_rise[v]);
        cnt_fall[v] += int'(gate_fall[v]);
      end
    end
  end

  task automatic wr(input logic [1:0] v, input logic [2:0] a, input logic [7:0] d,
                    input int hold = 1, input logic [1:0] junk = 2'b00);
    @(negedge clk);
    bus_if.ui_in  = {1'b0, junk, v, a};
    bus_if.uio_in = d;
    @(negedge clk);
    bus_if.ui_in[7] = 1'b1;
    repeat (hold) @(negedge clk);
    bus_if.ui_in[7] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  int c0, c1;

  initial begin
    bus_if.ui_in  = 8'h00;
    bus_if.uio_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_freq", 64'(freq), 64'd0);
    chk("reset_fc", 64'(fc), 64'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Test 1: commit latency, two edges after the strobe is first sampled.
    bus_if.ui_in  = 8'h00;
    bus_if.uio_in = 8'h24;
    @(negedge clk);
    bus_if.ui_in[7] = 1'b1;
    @(posedge clk);
    #2;
    @(negedge clk);
    bus_if.ui_in[7] = 1'b0;
    @(posedge clk);
    #2 chk("t1_before_commit", 64'(freq[15:0]), 64'h0);
    @(posedge clk);
    #2 chk("t1_after_commit", 64'(freq[15:0]), 64'h0024);
    chk("t1_other_voices", 64'(freq[47:16]), 64'h0);
    repeat (3) @(negedge clk);
    wr(2'd0, 3'd1, 8'h00);
    chk("t1_freq_v0", 64'(freq[15:0]), 64'h0024);

    // Test 2: pulse width, upper nibble of pw_hi dropped.
    c0 = cnt_wr;
    wr(2'd1, 3'd2, 8'h00);
    wr(2'd1, 3'd3, 8'hF8);
    chk("t2_pw_v1", 64'(pw[23:12]), 64'h800);
    chk("t2_wr_count", 64'(cnt_wr - c0), 64'd2);

    // Test 3: gate edges on voice 2.
    c0 = cnt_rise[2];
    c1 = cnt_fall[2];
    wr(2'd2, 3'd6, 8'h21);
    wr(2'd2, 3'd6, 8'h20);
    wr(2'd2, 3'd6, 8'h20);
    chk("t3_rise_count", 64'(cnt_rise[2] - c0), 64'd1);
    chk("t3_fall_count", 64'(cnt_fall[2] - c1), 64'd1);
    chk("t3_ctrl_v2", 64'(ctrl[23:16]), 64'h20);

    // Test 4: filter bank; ui_in[6:5] set on one write must be ignored.
    wr(2'd3, 3'd0, 8'hFF);
    wr(2'd3, 3'd1, 8'h20, 1, 2'b11);
    wr(2'd3, 3'd2, 8'h01);
    wr(2'd3, 3'd3, 8'h1F);
    chk("t4_fc", 64'(fc), 64'h107);
    chk("t4_res_filt", 64'(res_filt), 64'h01);
    chk("t4_mode_vol", 64'(mode_vol), 64'h1F);

    // Test 5: unmapped addresses.
    c0 = cnt_bad;
    c1 = cnt_wr;
    wr(2'd0, 3'd7, 8'hAA);
    wr(2'd3, 3'd5, 8'h55);
    chk("t5_bad_count", 64'(cnt_bad - c0), 64'd2);
    chk("t5_wr_count", 64'(cnt_wr - c1), 64'd2);
    chk("t5_freq_kept", 64'(freq[15:0]), 64'h0024);
    chk("t5_fc_kept", 64'(fc), 64'h107);

    // Test 6: long strobe gives one commit; reset mid-strobe drops the write.
    c0 = cnt_wr;
    wr(2'd0, 3'd4, 8'h9A, 10);
    chk("t6_long_strobe_count", 64'(cnt_wr - c0), 64'd1);
    chk("t6_ad_v0", 64'(ad[7:0]), 64'h9A);

    c0 = cnt_wr;
    @(negedge clk);
    bus_if.ui_in  = {1'b0, 2'b00, 2'd1, 3'd5};
    bus_if.uio_in = 8'h33;
    @(negedge clk);
    bus_if.ui_in[7] = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_rst_freq", 64'(freq), 64'h0);
    chk("t6_rst_ad", 64'(ad), 64'h0);
    chk("t6_rst_fc", 64'(fc), 64'h0);
    chk("t6_rst_mode", 64'(mode_vol), 64'h0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    bus_if.ui_in[7] = 1'b0;
    repeat (6) @(negedge clk);
    chk("t6_no_commit_after_rst", 64'(cnt_wr - c0), 64'd0);
    chk("t6_sr_still_zero", 64'(sr), 64'h0);

    wr(2'd1, 3'd5, 8'h77);
    chk("t6_rearm_sr_v1", 64'(sr[15:8]), 64'h77);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
